// File: rtl/stream_mux_pkg.sv
// Shared constants and output-register state type for the round-robin stream mux.
package stream_mux_pkg;

   localparam int N_IN_DEF = 4;
   localparam int W_DEF    = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } mux_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr, wrapping modulo N_IN.
module rr_arbiter #(
   parameter int N_IN = 4
) (
   input  logic [N_IN-1:0]         req,
   input  logic [$clog2(N_IN)-1:0] ptr,
   output logic                    gnt_valid,
   output logic [$clog2(N_IN)-1:0] gnt_idx
);

   localparam int IW = $clog2(N_IN);
   localparam int SW = IW + 1;

   logic [SW-1:0] cand;

   // Walk offsets from the far end so the closest match to ptr is written last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + SW'(i);
         if (cand >= SW'(N_IN)) begin
            cand = cand - SW'(N_IN);
         end
         if (req[cand[IW-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_rr_mux.sv
// N-input round-robin stream multiplexer with a single registered output slot.
//   state | meaning
//   EMPTY | output register holds no word, out_valid=0
//   FULL  | output register holds a word, out_valid=1
module stream_rr_mux
   import stream_mux_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int W    = W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_IN-1:0]           in_valid,
   input  logic [N_IN-1:0][W-1:0]    in_data,
   output logic [N_IN-1:0]           in_ready,
   output logic                      out_valid,
   output logic [W-1:0]              out_data,
   output logic [$clog2(N_IN)-1:0]   out_src,
   input  logic                      out_ready
);

   localparam int IW = $clog2(N_IN);

   mux_state_e    state_q, state_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic [IW-1:0] out_src_q, out_src_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;

   logic          load;
   logic          grant;
   logic          gnt_valid;
   logic [IW-1:0] gnt_idx;

   rr_arbiter #(
      .N_IN (N_IN)
   ) u_rr_arbiter (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // rst_n gates the grant so no handshake can be offered while the slot is being cleared.
   assign load  = (state_q == EMPTY) || out_ready;
   assign grant = rst_n && load && gnt_valid;

   always_comb begin
      in_ready = '0;
      if (grant) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         EMPTY: begin
            if (grant) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (grant) begin
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (grant) begin
         out_data_d = in_data[gnt_idx];
         out_src_d  = gnt_idx;
         rr_ptr_d   = (gnt_idx == IW'(N_IN - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_src_q  <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_rr_mux.sv
// Self-checking bench for stream_rr_mux: directed table, reset corner cases, randomized scoreboard run.
module tb_stream_rr_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        in_valid;
   logic [N-1:0][W-1:0] in_data;
   logic [N-1:0]        in_ready;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic [1:0]          out_src;
   logic                out_ready;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stream_rr_mux #(
      .N_IN (N),
      .W    (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   typedef struct {
      logic [3:0]      v;
      logic [3:0][7:0] d;
      logic            ordy;
      logic [3:0]      e_rdy;
      logic            e_ov;
      logic [7:0]      e_data;
      logic [1:0]      e_src;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
         end
      end
   endtask

   function automatic int first_from(input logic [3:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0][7:0] dd;
      logic [3:0]      vr;
      logic [3:0]      hs;
      logic [3:0]      exp_rdy;
      int              in_seq[N];
      int              out_seq[N];
      int              wait_c[N];
      int              in_cnt;
      int              out_cnt;
      int              eg;
      int              sidx;
      bit              ld;
      bit              m_valid;
      logic [7:0]      m_data;
      int              m_src;
      int              m_ptr;

      dd = {8'h13, 8'h12, 8'h11, 8'h10};
      //            v        d   ordy  e_rdy    ov    data    src
      tbl[0]  = '{4'b1111, dd, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[1]  = '{4'b1111, dd, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
      tbl[2]  = '{4'b1111, dd, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
      tbl[3]  = '{4'b1111, dd, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
      tbl[4]  = '{4'b1111, dd, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[5]  = '{4'b1111, dd, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
      tbl[6]  = '{4'b1111, dd, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
      tbl[7]  = '{4'b1111, dd, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
      tbl[8]  = '{4'b1111, dd, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
      tbl[9]  = '{4'b0100, dd, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
      tbl[10] = '{4'b1010, dd, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
      tbl[11] = '{4'b1010, dd, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
      tbl[12] = '{4'b0000, dd, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
      tbl[13] = '{4'b0000, dd, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd1};
      tbl[14] = '{4'b0001, dd, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[15] = '{4'b0001, dd, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};

      // Reset values before any clock edge
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_src", 32'(out_src), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single word from stream 0
      in_valid   = 4'b0001;
      in_data[0] = 8'hA5;
      out_ready  = 1'b1;
      @(negedge clk);
      chk("single_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("single_out_valid", 32'(out_valid), 1);
      chk("single_out_data", 32'(out_data), 32'hA5);
      chk("single_out_src", 32'(out_src), 0);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         in_valid  = tbl[i].v;
         in_data   = tbl[i].d;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_data));
         chk($sformatf("tbl%0d_out_src", i), 32'(out_src), 32'(tbl[i].e_src));
      end

      // Asynchronous reset while FULL, then search restarts at index 0
      in_valid  = 4'b0101;
      in_data   = dd;
      out_ready = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_data", 32'(out_data), 0);
      chk("arst_out_src", 32'(out_src), 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("arst_hold_in_ready", 32'(in_ready), 0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_rdy0", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("post_rst_src0", 32'(out_src), 0);
      chk("post_rst_data0", 32'(out_data), 32'h10);
      @(negedge clk);
      chk("post_rst_rdy2", 32'(in_ready), 32'h4);
      @(posedge clk);
      #1;
      chk("post_rst_src2", 32'(out_src), 2);
      chk("post_rst_data2", 32'(out_data), 32'h12);

      // Randomized traffic against a reference model and per-stream scoreboard
      do_reset();
      vr      = '0;
      hs      = '0;
      in_cnt  = 0;
      out_cnt = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
      for (int s = 0; s < N; s++) begin
         in_seq[s]  = 0;
         out_seq[s] = 0;
         wait_c[s]  = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int s = 0; s < N; s++) begin
            if (hs[s]) vr[s] = ($urandom_range(1, 0) == 1);
            else if (!vr[s]) vr[s] = ($urandom_range(2, 0) == 0);
            in_data[s] = {2'(s), 6'(in_seq[s])};
         end
         in_valid  = vr;
         out_ready = ($urandom_range(3, 0) != 0);
         @(negedge clk);
         ld      = !m_valid || out_ready;
         eg      = ld ? first_from(in_valid, m_ptr) : -1;
         exp_rdy = (eg >= 0) ? 4'(1 << eg) : 4'b0000;
         chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("rnd_onehot", 32'($countones(in_ready) <= 1), 1);
         chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rnd_out_data", 32'(out_data), 32'(m_data));
            chk("rnd_out_src", 32'(out_src), 32'(m_src));
         end
         if (out_valid && out_ready) begin
            sidx = int'(out_src);
            chk("rnd_order", 32'(out_data), 32'({out_src, 6'(out_seq[sidx])}));
            out_seq[sidx]++;
            out_cnt++;
         end
         if (eg >= 0) begin
            for (int s = 0; s < N; s++) begin
               if (s != eg && in_valid[s]) begin
                  wait_c[s]++;
                  chk($sformatf("rnd_starve%0d", s), 32'(wait_c[s] <= N - 1), 1);
               end
            end
            wait_c[eg] = 0;
         end
         hs = in_valid & in_ready;
         for (int s = 0; s < N; s++) begin
            if (hs[s]) begin
               in_seq[s]++;
               in_cnt++;
            end
         end
         if (eg >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[eg];
            m_src   = eg;
            m_ptr   = (eg + 1) % N;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      chk("rnd_conservation", 32'(in_cnt), 32'(out_cnt + int'(m_valid)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stream_rr_mux.md
STREAM_RR_MUX -- requirements
Module: stream_rr_mux

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of input streams (2..8).
REQ-002 The block SHALL have parameter W, default 8, meaning the data width in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid  input  N_IN  per-stream valid.
REQ-006 The block SHALL have port in_data  input  N_IN x W  per-stream data.
REQ-007 The block SHALL have port in_ready  output  N_IN  per-stream ready; at most one bit high per cycle.
REQ-008 The block SHALL have port out_valid  output  1  output register holds a word.
REQ-009 The block SHALL have port out_data  output  W  selected word.
REQ-010 The block SHALL have port out_src  output  $clog2(N_IN)  index of the stream that supplied out_data.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-012 A transfer SHALL occur on any port in a cycle where its valid and ready are both high at the rising edge.
REQ-013 The output register SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 The block SHALL compute load = !out_valid || out_ready, combinationally, in the same cycle.
REQ-015 When load=1 and any in_valid is high, the block SHALL grant exactly one stream g, the first valid index found searching upward from rr_ptr with wrap-around modulo N_IN.
REQ-016 The block SHALL drive in_ready[g]=1 only for the granted stream and only when load=1; all other in_ready bits SHALL be 0.
REQ-017 in_ready SHALL depend on in_valid, rr_ptr, out_valid and out_ready only, never on in_data.
REQ-018 On a grant, the block SHALL load out_data=in_data[g] and out_src=g at the next edge, and the FSM SHALL be FULL; latency is 1 cycle.
REQ-019 On a grant, the block SHALL update rr_ptr to (g+1) mod N_IN; without a grant, rr_ptr SHALL be unchanged.
REQ-020 When FULL with out_ready=1 and no in_valid high, the FSM SHALL go to EMPTY; out_data and out_src SHALL hold their last values.
REQ-021 When FULL with out_ready=1 and a grant present, the block SHALL drain and reload in the same cycle, sustaining one word per cycle.
REQ-022 When FULL with out_ready=0, the block SHALL hold out_valid, out_data and out_src stable, and all in_ready bits SHALL be 0.
REQ-023 A stream that stays valid SHALL be granted within N_IN grants, so no stream starves.
REQ-024 out_valid, out_data and out_src SHALL come directly from flops, with no combinational path from the inputs.

Reset
REQ-025 While rst_n=0, the block SHALL immediately force out_valid=0, out_data=0, out_src=0, rr_ptr=0 and the FSM to EMPTY, independent of clk.
REQ-026 Reset mid-transfer SHALL discard the word held in the output register; in_ready SHALL be 0 while rst_n=0.
REQ-027 After rst_n deasserts, the first grant SHALL search from index 0.

Structure
REQ-028 The shared package stream_mux_pkg SHALL hold the default N_IN and W constants and the FSM state enum (EMPTY, FULL).
REQ-029 The round-robin priority search SHALL be a combinational sub-module rr_arbiter (inputs req[N_IN] and ptr; outputs gnt_valid and gnt_idx), instantiated once.
REQ-030 All storage SHALL be in stream_rr_mux: the FSM/out_valid, out_data, out_src and rr_ptr.

Verification
REQ-031 The bench SHALL cover: reset, then in_valid=4'b0001, in_data[0]=8'hA5, out_ready=1 -> in_ready=4'b0001, and next cycle out_valid=1, out_data=8'hA5, out_src=0.
REQ-032 The bench SHALL cover: all four valid, data 8'h10/11/12/13, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-033 The bench SHALL cover: FULL with out_ready=0 for 3 cycles -> in_ready=0 and out_data unchanged; out_ready=1 -> drain and reload in the same cycle.
REQ-034 The bench SHALL cover: rr_ptr=3 with valid only on streams 1 and 3 -> grant 3, then 1 (wrap-around).
REQ-035 The bench SHALL cover: rst_n pulled low mid-cycle while FULL -> out_valid=0 immediately without a clock edge; after release, streams 2 and 0 valid -> grant 0 first.
REQ-036 The bench SHALL cover: random valid/ready over 10k cycles -> scoreboard checks per-stream order and no loss or duplication, at most one in_ready bit high, and every waiting stream granted within 4 grants.
